pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer_pkg.sv | 27 ++
 rtl/pixel_fifo.sv | 51 +++++
 rtl/pixel_writer.sv | 117 +++++++++++
 tb/tb_pixel_writer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel writer: FSM encoding, Kbus field layout
// and default screen geometry.
package pixel_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    localparam int KBUS_W = 24;
    localparam int X_MSB  = 23;
    localparam int X_LSB  = 16;
    localparam int Y_MSB  = 15;
    localparam int Y_LSB  = 8;
    localparam int C_MSB  = 7;
    localparam int C_LSB  = 0;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_ADDR_W   = 15;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small first-word-fall-through queue: dout always shows the head entry.
module pixel_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (do_pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Queues pixel commands, clips off-screen ones, and issues one framebuffer
// write per on-screen pixel with a valid/ack handshake.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KBUS_W-1:0] Kbus,
    input  logic              outEnable,
    output logic              kReady,
    output logic [ADDR_W-1:0] fbAddr,
    output logic [7:0]        fbData,
    output logic              fbWe,
    input  logic              fbAck,
    input  logic              clrStats,
    output logic [7:0]        clipCount,
    output logic              ovfFlag,
    output logic              busy
);
    localparam logic [31:0] SCR_W_U = 32'(SCREEN_W);
    localparam logic [31:0] SCR_H_U = 32'(SCREEN_H);

    state_e            state_q;
    logic [KBUS_W-1:0] stage_q;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_data_q;
    logic              fb_we_q;
    logic [7:0]        clip_q;
    logic              ovf_q;

    logic [KBUS_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]        pix_x, pix_y, pix_c;
    logic [31:0]       lin_addr;
    logic              in_range;

    // kReady looks only at the registered count, so a same-cycle pop never frees a slot
    assign kReady    = ~fifo_full;
    assign fifo_push = outEnable & ~fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

    pixel_fifo #(.WIDTH(KBUS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (Kbus),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign pix_x     = stage_q[X_MSB:X_LSB];
    assign pix_y     = stage_q[Y_MSB:Y_LSB];
    assign pix_c     = stage_q[C_MSB:C_LSB];
    assign in_range  = (32'(pix_x) < SCR_W_U) && (32'(pix_y) < SCR_H_U);
    assign lin_addr  = 32'(pix_y) * SCR_W_U + 32'(pix_x);
    assign fb_addr_d = lin_addr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            fb_we_q   <= 1'b0;
            clip_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        stage_q <= fifo_dout;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (in_range) begin
                        fb_addr_q <= fb_addr_d;
                        fb_data_q <= pix_c;
                        fb_we_q   <= 1'b1;
                        state_q   <= ST_WRITE;
                    end else begin
                        clip_q  <= sat_inc8(clip_q);
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (fbAck) begin
                        fb_we_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (outEnable && fifo_full) ovf_q <= 1'b1;
            // Placed last so a clear beats any increment or set in the same cycle
            if (clrStats) begin
                clip_q <= '0;
                ovf_q  <= 1'b0;
            end
        end
    end

    assign fbAddr    = fb_addr_q;
    assign fbData    = fb_data_q;
    assign fbWe      = fb_we_q;
    assign clipCount = clip_q;
    assign ovfFlag   = ovf_q;
    assign busy      = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer with a write scoreboard fed at push time.
module tb_pixel_writer;
    import pixel_writer_pkg::*;

    localparam int SW = DEF_SCREEN_W;
    localparam int SH = DEF_SCREEN_H;
    localparam int AW = DEF_ADDR_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [23:0]   Kbus = '0;
    logic          outEnable = 1'b0;
    logic          kReady;
    logic [AW-1:0] fbAddr;
    logic [7:0]    fbData;
    logic          fbWe;
    logic          fbAck = 1'b1;
    logic          clrStats = 1'b0;
    logic [7:0]    clipCount;
    logic          ovfFlag;
    logic          busy;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int wr_cnt   = 0;
    bit gap_chk  = 0;
    logic [AW+7:0] exp_q [$];

    pixel_writer #(.SCREEN_W(SW), .SCREEN_H(SH), .FIFO_DEPTH(4), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .Kbus(Kbus), .outEnable(outEnable), .kReady(kReady),
        .fbAddr(fbAddr), .fbData(fbData), .fbWe(fbWe), .fbAck(fbAck),
        .clrStats(clrStats), .clipCount(clipCount), .ovfFlag(ovfFlag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c,
                            input bit exp_en);
        int a;
        Kbus      = {x, y, c};
        outEnable = 1'b1;
        a = int'(y) * SW + int'(x);
        if (exp_en && kReady && int'(x) < SW && int'(y) < SH)
            exp_q.push_back({AW'(a), c});
        tick();
        outEnable = 1'b0;
    endtask

    task automatic wait_we();
        for (int i = 0; i < 50 && !fbWe; i++) tick();
        check("wait_fbWe", 32'(fbWe), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (busy || fbWe); i++) tick();
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    // Write monitor: a write completes at the next edge when fbWe and fbAck are both high
    always @(negedge clk) begin
        if (rst_n) begin
            if (gap_chk) check("gap_fbWe_low", 32'(fbWe), 32'd0);
            gap_chk = 0;
            if (fbWe && fbAck) begin
                wr_cnt++;
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("write_addr_data", 32'({fbAddr, fbData}), 32'(exp_q.pop_front()));
                gap_chk = 1;
            end
        end
    end

    initial begin
        int acc;
        int wr_before;
        // Reset state
        #2;
        check("rst_fbWe", 32'(fbWe), 32'd0);
        check("rst_fbAddr", 32'(fbAddr), 32'd0);
        check("rst_fbData", 32'(fbData), 32'd0);
        check("rst_clip", 32'(clipCount), 32'd0);
        check("rst_ovf", 32'(ovfFlag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_kReady", 32'(kReady), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write and minimum latency
        push_cmd(8'd5, 8'd2, 8'hA3, 1);
        check("lat_k", 32'(fbWe), 32'd0);
        tick();
        check("lat_k1", 32'(fbWe), 32'd0);
        tick();
        check("lat_k2_we", 32'(fbWe), 32'd1);
        check("lat_k2_addr", 32'(fbAddr), 32'd325);
        check("lat_k2_data", 32'(fbData), 32'hA3);
        tick();
        check("single_we_low", 32'(fbWe), 32'd0);
        wait_idle();
        check("single_wr_cnt", 32'(wr_cnt), 32'd1);

        // Clipping boundaries
        push_cmd(8'd160, 8'd0, 8'h01, 1);
        push_cmd(8'd0, 8'd120, 8'h02, 1);
        push_cmd(8'd159, 8'd119, 8'h3C, 1);
        wait_idle();
        check("clip_count", 32'(clipCount), 32'd2);
        check("clip_wr_cnt", 32'(wr_cnt), 32'd2);

        // Overflow with fbAck held low
        fbAck = 1'b0;
        check("ovf_pre", 32'(ovfFlag), 32'd0);
        for (int i = 0; i < 6; i++) begin
            Kbus      = {8'(i), 8'd1, 8'(8'h10 + i)};
            outEnable = 1'b1;
            check("ovf_kready", 32'(kReady), (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) exp_q.push_back({AW'(SW + i), 8'(8'h10 + i)});
            tick();
        end
        outEnable = 1'b0;
        check("ovf_flag", 32'(ovfFlag), 32'd1);
        tick();
        tick();
        fbAck = 1'b1;
        wait_idle();
        check("ovf_drained", 32'(exp_q.size()), 32'd0);
        check("ovf_wr_cnt", 32'(wr_cnt), 32'd7);

        // Statistics clear
        clrStats = 1'b1;
        tick();
        clrStats = 1'b0;
        check("clr_ovf", 32'(ovfFlag), 32'd0);
        check("clr_clip", 32'(clipCount), 32'd0);

        // Stall: fbAck low for 7 cycles
        fbAck = 1'b0;
        push_cmd(8'd10, 8'd3, 8'h5C, 1);
        wait_we();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) fbAck = 1'b1;
            check("stall_we", 32'(fbWe), 32'd1);
            check("stall_addr", 32'(fbAddr), 32'd490);
            check("stall_data", 32'(fbData), 32'h5C);
            tick();
        end
        check("stall_done", 32'(fbWe), 32'd0);
        check("stall_wr_cnt", 32'(wr_cnt), 32'd8);

        // Reset mid-WRITE abandons the write
        fbAck = 1'b0;
        push_cmd(8'd20, 8'd20, 8'h77, 0);
        wait_we();
        push_cmd(8'd21, 8'd20, 8'h78, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_fbWe", 32'(fbWe), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_kReady", 32'(kReady), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        fbAck = 1'b1;
        wr_before = wr_cnt;
        repeat (20) tick();
        check("rstw_no_write", 32'(wr_cnt), 32'(wr_before));
        check("rstw_idle", 32'(busy), 32'd0);

        // Saturation after 300 clipped commands
        acc = 0;
        for (int c = 0; c < 3000 && acc < 300; c++) begin
            if (kReady) begin
                Kbus      = {8'd200, 8'd0, 8'h11};
                outEnable = 1'b1;
                acc++;
            end else begin
                outEnable = 1'b0;
            end
            tick();
        end
        outEnable = 1'b0;
        check("sat_pushes", 32'(acc), 32'd300);
        wait_idle();
        check("sat_clip", 32'(clipCount), 32'd255);

        // clrStats wins over a clip in CHECK the same cycle
        push_cmd(8'd0, 8'd200, 8'h22, 1);
        tick();
        check("prio_pre", 32'(clipCount), 32'd255);
        clrStats = 1'b1;
        tick();
        clrStats = 1'b0;
        check("prio_clip", 32'(clipCount), 32'd0);
        wait_idle();
        check("prio_after", 32'(clipCount), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
